// File: rtl/l2_writeback_buffer_if.sv
// Bus bundle between the L2 pmem port, the write-back buffer and physical memory.
// Latency: none, wiring only.
// Backpressure: request/resp hold-until-resp handshake on both the L2 and memory sides.
interface l2_writeback_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   // L2-facing side
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_rdata;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic              mem_resp;

   // memory-facing side
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_rdata;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_read;
   logic              pmem_write;
   logic              pmem_resp;

   // status
   logic              wb_full;

   // the buffer itself: takes L2 requests, issues memory requests
   modport slave (
      input  mem_address, mem_wdata, mem_read, mem_write,
      input  pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_wdata, pmem_read, pmem_write,
      output wb_full
   );

   // the environment: L2 requester plus memory responder
   modport master (
      output mem_address, mem_wdata, mem_read, mem_write,
      output pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_wdata, pmem_read, pmem_write,
      input  wb_full
   );
endinterface

// File: rtl/l2_writeback_buffer.sv
// Single-entry write-back buffer between the L2 pmem port and physical memory.
// Latency: 1 cycle to mem_resp for buffered writes/read hits; misses and drains follow memory latency.
// Backpressure: L2 holds its request until mem_resp; fills pre-empt an idle drain, an active drain is never aborted.
module l2_writeback_buffer #(
   parameter int ADDR_W   = 32,
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   l2_writeback_buffer_if.slave  bus
);

   localparam int TAG_W = ADDR_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic              valid;
   logic [TAG_W-1:0]  tag;
   logic [LINE_W-1:0] data;
   logic [LINE_W-1:0] rdata_q;

   logic [TAG_W-1:0]  req_tag;
   logic              match;

   // IDLE decode of the pending L2 request; read always wins over a simultaneous write
   logic              rd_hit;
   logic              rd_miss;
   logic              wr_capture;
   logic              wr_evict;
   logic              idle_drain;

   // memory-side strobes and the outputs they produce
   logic              pmem_read_c;
   logic              pmem_write_c;
   logic              mem_resp_c;
   logic [ADDR_W-1:0] pmem_address_c;

   assign req_tag = bus.mem_address[ADDR_W-1:OFFSET_W];
   assign match   = valid && (req_tag == tag);

   // classify the current L2 request as seen from IDLE
   always_comb begin
      rd_hit     = 1'b0;
      rd_miss    = 1'b0;
      wr_capture = 1'b0;
      wr_evict   = 1'b0;
      idle_drain = 1'b0;
      if (state == IDLE) begin
         if (bus.mem_read) begin
            rd_hit  = match;
            rd_miss = !match;
         end else if (bus.mem_write) begin
            wr_capture = !valid || match;
            wr_evict   = valid && !match;
         end else begin
            idle_drain = valid;
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (rd_hit || wr_capture) begin
               state_nx = RESP;
            end else if (rd_miss) begin
               state_nx = READ;
            end else if (wr_evict || idle_drain) begin
               state_nx = DRAIN;
            end else begin
               state_nx = IDLE;
            end
         end
         READ: begin
            if (bus.pmem_resp) begin
               state_nx = RESP;
            end
         end
         DRAIN: begin
            // the blocked write (if any) is re-evaluated from IDLE once the line is out
            if (bus.pmem_resp) begin
               state_nx = IDLE;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // output decode, purely from state so read and write strobes are exclusive
   always_comb begin
      pmem_read_c    = 1'b0;
      pmem_write_c   = 1'b0;
      mem_resp_c     = 1'b0;
      pmem_address_c = '0;
      unique case (state)
         READ: begin
            pmem_read_c    = 1'b1;
            pmem_address_c = {req_tag, {OFFSET_W{1'b0}}};
         end
         DRAIN: begin
            pmem_write_c   = 1'b1;
            pmem_address_c = {tag, {OFFSET_W{1'b0}}};
         end
         RESP: begin
            mem_resp_c = 1'b1;
         end
         default: begin
            pmem_address_c = '0;
         end
      endcase
   end

   // buffered line and read-return register; reset drops any undrained line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         tag     <= '0;
         data    <= '0;
         rdata_q <= '0;
      end else begin
         if (wr_capture) begin
            // same-line writes coalesce onto the existing entry
            valid <= 1'b1;
            tag   <= req_tag;
            data  <= bus.mem_wdata;
         end else if ((state == DRAIN) && bus.pmem_resp) begin
            valid <= 1'b0;
         end

         if (rd_hit) begin
            rdata_q <= data;
         end else if ((state == READ) && bus.pmem_resp) begin
            rdata_q <= bus.pmem_rdata;
         end
      end
   end

   assign bus.mem_rdata    = rdata_q;
   assign bus.mem_resp     = mem_resp_c;
   assign bus.pmem_address = pmem_address_c;
   assign bus.pmem_wdata   = data;
   assign bus.pmem_read    = pmem_read_c;
   assign bus.pmem_write   = pmem_write_c;
   assign bus.wb_full      = valid;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for the single-entry L2 write-back buffer.
// Latency: checks 1-cycle acks, miss/drain latency with a hand-driven memory.
// Backpressure: L2 and memory handshakes are driven step by step from one initial block.
module tb_l2_writeback_buffer;

   localparam int ADDR_W   = 32;
   localparam int LINE_W   = 256;
   localparam int OFFSET_W = 5;

   localparam logic [LINE_W-1:0] D1 = {8{32'h1111_0001}};
   localparam logic [LINE_W-1:0] D2 = {8{32'h2222_0002}};
   localparam logic [LINE_W-1:0] D3 = {8{32'h3333_0003}};
   localparam logic [LINE_W-1:0] DB = {8{32'hBBBB_000B}};

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   l2_writeback_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   l2_writeback_buffer #(
      .ADDR_W   (ADDR_W),
      .LINE_W   (LINE_W),
      .OFFSET_W (OFFSET_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one clock; outputs are then observed 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_mem_resp"}, LINE_W'(bus.mem_resp), '0);
      chk({tag, "_pmem_read"}, LINE_W'(bus.pmem_read), '0);
      chk({tag, "_pmem_write"}, LINE_W'(bus.pmem_write), '0);
   endtask

   task automatic l2_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      bus.mem_address = a;
      bus.mem_wdata   = d;
      bus.mem_write   = 1'b1;
      bus.mem_read    = 1'b0;
   endtask

   task automatic l2_read(input logic [ADDR_W-1:0] a);
      bus.mem_address = a;
      bus.mem_read    = 1'b1;
      bus.mem_write   = 1'b0;
   endtask

   task automatic l2_drop();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   // one-cycle memory completion pulse
   task automatic mem_pulse(input logic [LINE_W-1:0] rd);
      bus.pmem_rdata = rd;
      bus.pmem_resp  = 1'b1;
      tick();
      bus.pmem_resp  = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.mem_address = '0;
      bus.mem_wdata   = '0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.pmem_rdata  = '0;
      bus.pmem_resp   = 1'b0;

      // ---- reset then five idle cycles
      tick();
      tick();
      chk_idle_outs("rst");
      chk("rst_wb_full", LINE_W'(bus.wb_full), '0);
      chk("rst_rdata", bus.mem_rdata, '0);
      chk("rst_paddr", LINE_W'(bus.pmem_address), '0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle_outs("idle");
         chk("idle_wb_full", LINE_W'(bus.wb_full), '0);
      end

      // ---- write to empty buffer, then idle drain
      l2_write(32'h0000_1040, D1);
      tick();
      chk("w1_resp", LINE_W'(bus.mem_resp), 1);
      chk("w1_full", LINE_W'(bus.wb_full), 1);
      l2_drop();
      tick();
      chk_idle_outs("w1_idle");
      tick();
      chk("w1_drain_pw", LINE_W'(bus.pmem_write), 1);
      chk("w1_drain_pr", LINE_W'(bus.pmem_read), 0);
      chk("w1_drain_addr", LINE_W'(bus.pmem_address), LINE_W'(32'h0000_1040));
      chk("w1_drain_wdata", bus.pmem_wdata, D1);
      tick();
      chk("w1_drain_hold", LINE_W'(bus.pmem_write), 1);
      mem_pulse('0);
      chk("w1_drained_full", LINE_W'(bus.wb_full), 0);
      chk_idle_outs("w1_done");

      // ---- write A, read hit on the same line
      l2_write(32'h0000_1040, D1);
      tick();
      chk("hit_wresp", LINE_W'(bus.mem_resp), 1);
      l2_read(32'h0000_1044);
      tick();
      chk_idle_outs("hit_idle");
      tick();
      chk("hit_resp", LINE_W'(bus.mem_resp), 1);
      chk("hit_rdata", bus.mem_rdata, D1);
      chk("hit_no_pread", LINE_W'(bus.pmem_read), 0);
      l2_drop();
      tick();
      chk("hit_resp_once", LINE_W'(bus.mem_resp), 0);
      tick();
      chk("hit_drain_pw", LINE_W'(bus.pmem_write), 1);
      chk("hit_drain_wdata", bus.pmem_wdata, D1);
      mem_pulse('0);
      chk("hit_drained", LINE_W'(bus.wb_full), 0);

      // ---- write A, read miss on B before drain (3-cycle memory)
      l2_write(32'h0000_1040, D1);
      tick();
      chk("miss_wresp", LINE_W'(bus.mem_resp), 1);
      l2_read(32'h0000_2000);
      tick();
      chk_idle_outs("miss_idle");
      tick();
      chk("miss_pr1", LINE_W'(bus.pmem_read), 1);
      chk("miss_pw1", LINE_W'(bus.pmem_write), 0);
      chk("miss_addr", LINE_W'(bus.pmem_address), LINE_W'(32'h0000_2000));
      tick();
      chk("miss_pr2", LINE_W'(bus.pmem_read), 1);
      tick();
      chk("miss_pr3", LINE_W'(bus.pmem_read), 1);
      mem_pulse(DB);
      chk("miss_resp", LINE_W'(bus.mem_resp), 1);
      chk("miss_rdata", bus.mem_rdata, DB);
      chk("miss_full", LINE_W'(bus.wb_full), 1);
      chk("miss_pr_off", LINE_W'(bus.pmem_read), 0);
      l2_drop();
      tick();
      tick();
      chk("miss_drain_pw", LINE_W'(bus.pmem_write), 1);
      chk("miss_drain_addr", LINE_W'(bus.pmem_address), LINE_W'(32'h0000_1040));
      chk("miss_drain_wdata", bus.pmem_wdata, D1);
      mem_pulse('0);
      chk("miss_drained", LINE_W'(bus.wb_full), 0);

      // ---- coalesce A, then conflicting write B forces a drain first
      l2_write(32'h0000_1040, D1);
      tick();
      chk("co_w1resp", LINE_W'(bus.mem_resp), 1);
      l2_write(32'h0000_1048, D2);
      tick();
      chk_idle_outs("co_idle");
      tick();
      chk("co_resp", LINE_W'(bus.mem_resp), 1);
      chk("co_wdata", bus.pmem_wdata, D2);
      l2_write(32'h0000_3000, D3);
      tick();
      chk_idle_outs("co_idle2");
      tick();
      chk("co_drain_pw", LINE_W'(bus.pmem_write), 1);
      chk("co_drain_addr", LINE_W'(bus.pmem_address), LINE_W'(32'h0000_1040));
      chk("co_drain_wdata", bus.pmem_wdata, D2);
      chk("co_drain_noresp", LINE_W'(bus.mem_resp), 0);
      mem_pulse('0);
      chk("co_d1_full", LINE_W'(bus.wb_full), 0);
      chk("co_d1_noresp", LINE_W'(bus.mem_resp), 0);
      tick();
      chk("co_b_resp", LINE_W'(bus.mem_resp), 1);
      chk("co_b_full", LINE_W'(bus.wb_full), 1);
      l2_drop();
      tick();
      tick();
      chk("co_b_drain_addr", LINE_W'(bus.pmem_address), LINE_W'(32'h0000_3000));
      chk("co_b_drain_wdata", bus.pmem_wdata, D3);
      chk("co_b_drain_pw", LINE_W'(bus.pmem_write), 1);

      // ---- reset mid-drain, late memory response ignored
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rd_pw", LINE_W'(bus.pmem_write), 0);
      chk("rd_full", LINE_W'(bus.wb_full), 0);
      chk("rd_paddr", LINE_W'(bus.pmem_address), '0);
      mem_pulse(DB);
      chk_idle_outs("rd_late");
      tick();
      chk_idle_outs("rd_late2");
      chk("rd_full2", LINE_W'(bus.wb_full), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
